spi_frame_packer: RTL and testbench

// Packs multi-channel FFT output samples into fixed-length, DMA-friendly SPI frames for the ESP32 link.

---
 rtl/spi_frame_packer.sv | 163 ++++++++++++++++
 tb/tb_spi_frame_packer.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/spi_frame_packer.sv
// rtl/spi_frame_packer.sv - packs samples into fixed-length SPI frames with gaps and bursts; optional CRC-8 trailer via SPI_CRC8_EN
module spi_frame_packer #(
    parameter int          SAMPLE_BYTES     = 6,
    parameter int          FRAME_BYTES      = 8,
    parameter int          NUM_CH           = 3,
    parameter logic [7:0]  PAD_BYTE         = 8'hAB,
    parameter int          GAP_CYCLES       = 500_000,
    parameter int          FRAMES_PER_BURST = 1024
) (
    input  logic                      CLK100MHZ,
    input  logic                      rst_n,
    input  logic                      start_burst,
    input  logic                      s_valid,
    output logic                      s_ready,
    input  logic [8*SAMPLE_BYTES-1:0] s_data,
    input  logic [3:0]                s_ch,
    output logic [4:0]                m_tx_count,
    output logic [7:0]                m_tx_byte,
    output logic                      m_tx_dv,
    input  logic                      m_tx_ready,
    output logic                      busy,
    output logic                      burst_done,
    output logic [15:0]               frame_cnt
);

    localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

    if (NUM_CH < 1 || NUM_CH > 16 || FRAME_BYTES > 24 || FRAME_BYTES < SAMPLE_BYTES + 1) begin : g_bad_cfg
        $error("spi_frame_packer: illegal NUM_CH/FRAME_BYTES/SAMPLE_BYTES combination");
    end
`ifdef SPI_CRC8_EN
    if (FRAME_BYTES < SAMPLE_BYTES + 2) begin : g_bad_crc
        $error("spi_frame_packer: FRAME_BYTES too small for CRC trailer");
    end
`endif

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SEND, S_WAIT, S_GAP, S_DONE} state_t;

    state_t                    state, state_n;
    logic [8*SAMPLE_BYTES-1:0] sample_q;
    logic [3:0]                ch_q;
    logic [3:0]                seq;
    logic [4:0]                byte_idx;
    logic [GW-1:0]             gap_cnt;
    logic                      seen_low;
    logic                      strobe, wait_done, last_byte, gap_last;
    logic [7:0]                frame_byte;
`ifdef SPI_CRC8_EN
    logic [7:0]                crc;

    function automatic logic [7:0] crc8_byte(input logic [7:0] c, input logic [7:0] d);
        logic [7:0] r;
        r = c ^ d;
        for (int b = 0; b < 8; b++) begin
            r = r[7] ? ({r[6:0], 1'b0} ^ 8'h07) : {r[6:0], 1'b0};
        end
        return r;
    endfunction
`endif

    assign m_tx_count = 5'(FRAME_BYTES);
    assign last_byte  = (byte_idx == 5'(FRAME_BYTES - 1));
    assign gap_last   = (GAP_CYCLES == 0) || (gap_cnt == GW'(GAP_CYCLES - 1));
    // Only advance after ready has been seen low, so a lagging ready cannot retrigger a strobe.
    assign wait_done  = (state == S_WAIT) && seen_low && m_tx_ready;

    always_comb begin
        frame_byte = PAD_BYTE;
        if (byte_idx == 5'd0) frame_byte = {seq, ch_q};
        for (int i = 0; i < SAMPLE_BYTES; i++) begin
            if (byte_idx == 5'(i + 1)) frame_byte = sample_q[(SAMPLE_BYTES-1-i)*8 +: 8];
        end
`ifdef SPI_CRC8_EN
        if (last_byte) frame_byte = crc;
`endif
    end

    always_ff @(posedge CLK100MHZ or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n    = state;
        s_ready    = 1'b0;
        busy       = (state != S_IDLE);
        burst_done = 1'b0;
        strobe     = 1'b0;
        case (state)
            S_IDLE: if (start_burst) state_n = S_LOAD;
            S_LOAD: begin
                s_ready = 1'b1;
                if (s_valid) state_n = S_SEND;
            end
            S_SEND: if (m_tx_ready) begin
                strobe  = 1'b1;
                state_n = S_WAIT;
            end
            S_WAIT: if (wait_done) state_n = last_byte ? S_GAP : S_SEND;
            S_GAP: if (gap_last) begin
                if (FRAMES_PER_BURST != 0 && frame_cnt == 16'(FRAMES_PER_BURST)) state_n = S_DONE;
                else state_n = S_LOAD;
            end
            S_DONE: begin
                burst_done = 1'b1;
                state_n    = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK100MHZ or negedge rst_n) begin
        if (!rst_n) begin
            sample_q  <= '0;
            ch_q      <= '0;
            seq       <= '0;
            byte_idx  <= '0;
            gap_cnt   <= '0;
            seen_low  <= 1'b0;
            frame_cnt <= '0;
            m_tx_dv   <= 1'b0;
            m_tx_byte <= PAD_BYTE;
`ifdef SPI_CRC8_EN
            crc       <= '0;
`endif
        end else begin
            m_tx_dv <= strobe;
            if (state == S_IDLE && start_burst) begin
                seq       <= '0;
                frame_cnt <= '0;
            end
            if (state == S_LOAD && s_valid) begin
                sample_q <= s_data;
                ch_q     <= s_ch;
                byte_idx <= '0;
`ifdef SPI_CRC8_EN
                crc      <= '0;
`endif
            end
            if (strobe) begin
                m_tx_byte <= frame_byte;
`ifdef SPI_CRC8_EN
                crc       <= crc8_byte(crc, frame_byte);
`endif
            end
            if (state != S_WAIT)  seen_low <= 1'b0;
            else if (!m_tx_ready) seen_low <= 1'b1;
            if (wait_done) begin
                if (last_byte) begin
                    frame_cnt <= frame_cnt + 16'd1;
                    gap_cnt   <= '0;
                end else begin
                    byte_idx <= byte_idx + 5'd1;
                end
            end
            if (state == S_GAP) begin
                gap_cnt <= gap_cnt + GW'(1);
                if (gap_last) seq <= seq + 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_spi_frame_packer.sv
// tb/tb_spi_frame_packer.sv - scoreboard bench for spi_frame_packer; define SPI_CRC8_EN to check the CRC trailer
module tb_spi_frame_packer;

    localparam int GAP = 10;
    localparam int FPB = 18;

    logic        clk = 1'b0;
    logic        rst_n, start_burst, s_valid, s_ready, m_tx_dv, m_tx_ready, busy, burst_done;
    logic [47:0] s_data;
    logic [3:0]  s_ch;
    logic [4:0]  m_tx_count;
    logic [7:0]  m_tx_byte;
    logic [15:0] frame_cnt;

    spi_frame_packer #(
        .SAMPLE_BYTES(6), .FRAME_BYTES(8), .NUM_CH(3), .PAD_BYTE(8'hAB),
        .GAP_CYCLES(GAP), .FRAMES_PER_BURST(FPB)
    ) dut (
        .CLK100MHZ(clk), .rst_n(rst_n), .start_burst(start_burst),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_ch(s_ch),
        .m_tx_count(m_tx_count), .m_tx_byte(m_tx_byte), .m_tx_dv(m_tx_dv),
        .m_tx_ready(m_tx_ready), .busy(busy), .burst_done(burst_done), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    logic [7:0] exp_q[$];
    logic [7:0] mon_exp;
    logic       prev_dv = 1'b0;
    int         checks = 0, failures = 0, dv_count = 0, hold = 1;
    time        last_dv_t = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    function automatic logic [7:0] crc8_model(input logic [7:0] c, input logic [7:0] d);
        logic [7:0] r;
        r = c;
        for (int b = 7; b >= 0; b--) begin
            if (r[7] ^ d[b]) r = {r[6:0], 1'b0} ^ 8'h07;
            else             r = {r[6:0], 1'b0};
        end
        return r;
    endfunction

    task automatic push_frame(input logic [47:0] d, input logic [3:0] ch, input logic [3:0] seq);
        logic [7:0] f[8];
        logic [7:0] c;
        f[0] = {seq, ch};
        for (int i = 0; i < 6; i++) f[i+1] = d[(5-i)*8 +: 8];
        f[7] = 8'hAB;
`ifdef SPI_CRC8_EN
        c = 8'h00;
        for (int i = 0; i < 7; i++) c = crc8_model(c, f[i]);
        f[7] = c;
`else
        c = 8'h00;
`endif
        for (int i = 0; i < 8; i++) exp_q.push_back(f[i]);
    endtask

    // Scoreboard monitor: every strobed byte is popped against the expected stream.
    always @(negedge clk) begin
        if (rst_n && m_tx_dv) begin
            dv_count++;
            last_dv_t = $time;
            checks++;
            if (prev_dv) begin
                failures++;
                $display("FAIL dv_double got=2-cycle strobe exp=1");
            end else if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL byte_unexpected got=%h exp=none", m_tx_byte);
            end else begin
                mon_exp = exp_q.pop_front();
                if (m_tx_byte !== mon_exp) begin
                    failures++;
                    $display("FAIL byte[%0d] got=%h exp=%h", dv_count, m_tx_byte, mon_exp);
                end
            end
        end
        prev_dv = rst_n && m_tx_dv;
    end

    // SPI master model: drops ready after each strobe for `hold` cycles.
    initial begin
        m_tx_ready = 1'b1;
        forever begin
            @(negedge clk);
            if (rst_n && m_tx_dv) begin
                m_tx_ready = 1'b0;
                repeat (hold) @(negedge clk);
                m_tx_ready = 1'b1;
            end
        end
    end

    task automatic pulse_start();
        start_burst = 1'b1;
        @(negedge clk);
        start_burst = 1'b0;
    endtask

    task automatic send_sample(input logic [47:0] d, input logic [3:0] ch, input logic [3:0] seq);
        int n;
        push_frame(d, ch, seq);
        s_data  = d;
        s_ch    = ch;
        s_valid = 1'b1;
        n = 0;
        while (!s_ready && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (!s_ready) begin
            checks++;
            failures++;
            $display("FAIL s_ready_timeout got=0 exp=1");
        end
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    task automatic wait_q_empty(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 20000) begin
            @(negedge clk);
            n++;
        end
        check(name, exp_q.size(), 0);
    endtask

    initial begin
        int  n, k;
        time dt;
        rst_n = 1'b0; start_burst = 1'b0; s_valid = 1'b0; s_data = '0; s_ch = '0;
        repeat (3) @(negedge clk);
        check("rst_dv", m_tx_dv, 0);
        check("rst_s_ready", s_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_burst_done", burst_done, 0);
        check("rst_frame_cnt", frame_cnt, 0);
        check("rst_tx_byte", m_tx_byte, 8'hAB);
        check("rst_tx_count", m_tx_count, 8);
        rst_n = 1'b1;
        @(negedge clk);
        pulse_start();
        check("busy_after_start", busy, 1);
        check("s_ready_load", s_ready, 1);

        // Frame 0 -> 02 F1 02 03 04 05 6F AB; frame 1 header 11 under 37-cycle back-pressure; ch 5 sent as-is.
        hold = 1;
        send_sample(48'hF1020304056F, 4'd2, 4'd0);
        hold = 37;
        send_sample(48'h0A1B2C3D4E5F, 4'd1, 4'd1);
        hold = 2;
        send_sample(48'h112233445566, 4'd5, 4'd2);
        wait_q_empty("frames0_2_drain");
        n = 0;
        while (!s_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("frame_cnt_3", frame_cnt, 3);

        k = dv_count;
        repeat (1000) @(negedge clk);
        check("stall_no_dv", dv_count, k);
        check("stall_busy", busy, 1);
        check("stall_s_ready", s_ready, 1);

        hold = 1;
        for (int i = 3; i < FPB; i++) begin
            send_sample({8'(i), 8'hC0, 8'h00, 8'hFF, 8'h5A, 8'(8'hA5 ^ 8'(i))}, 4'(i % 3), 4'(i));
        end
        wait_q_empty("burst_drain");
        n = 0;
        while (!burst_done && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("burst_done_seen", burst_done, 1);
        // Last strobe -> ready low, ready high (2 cycles) -> 10 gap cycles -> DONE.
        dt = ($time - last_dv_t) / 10;
        check("burst_done_delay", 32'(dt), GAP + 2);
        check("frame_cnt_burst", frame_cnt, FPB);
        @(negedge clk);
        check("burst_done_width", burst_done, 0);
        check("busy_dropped", busy, 0);
        check("frame_cnt_holds", frame_cnt, FPB);

        // Reset in the middle of a frame.
        pulse_start();
        send_sample(48'hDEADBEEF0001, 4'd0, 4'd0);
        k = 0;
        n = 0;
        while (k < 4 && n < 1000) begin
            @(negedge clk);
            if (m_tx_dv) k++;
            n++;
        end
        check("reset_reached_byte3", k, 4);
        #1 rst_n = 1'b0;
        #1;
        check("rst_mid_dv", m_tx_dv, 0);
        check("rst_mid_s_ready", s_ready, 0);
        check("rst_mid_busy", busy, 0);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        pulse_start();
        send_sample(48'h0102030405FE, 4'd2, 4'd0);
        wait_q_empty("after_reset_drain");
        repeat (3) @(negedge clk);
        check("frame_cnt_after_reset", frame_cnt, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
